// File: rtl/rr_sel_pkg.sv
// Shared constants and types for the round-robin select arbiter.
package rr_sel_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } rr_state_t;

  // Next search start after a release: the index just past the owner, wrapping 7 to 0.
  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/rr_sel_arbiter_pick.sv
// rr_pick: combinational rotate-priority search. It returns the first set request
// at or after ptr, searching upward and wrapping from 7 to 0.
module rr_pick
  import rr_sel_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand_s;

  // Walk the eight positions starting at ptr; the first hit wins.
  always_comb begin
    idx    = ptr;
    any    = 1'b0;
    cand_s = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = ptr + IDX_W'(i);
      if (!any && req[cand_s]) begin
        idx = cand_s;
        any = 1'b1;
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter that drives the registered 3-to-8 decoder select lines.
// Optional hold timeout is enabled by defining RR_HOLD_TIMEOUT_EN.
module rr_sel_arbiter
  import rr_sel_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic               gnt_valid,
  output logic               s2,
  output logic               s1,
  output logic               s0,
  output logic               timeout
);

  if (HOLD_MAX < 1) begin : g_bad_hold_max
    $error("rr_sel_arbiter: HOLD_MAX must be at least 1");
  end

  rr_state_t        state_r, state_s;
  logic [IDX_W-1:0] sel_r, sel_s;
  logic [IDX_W-1:0] ptr_r, ptr_s;
  logic             gnt_valid_r, gnt_valid_s;
  logic             timeout_r, timeout_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_any_s;
  logic             owner_req_s;
  logic             hold_expired_s;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_r),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  assign owner_req_s = req[sel_r];

`ifdef RR_HOLD_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] hold_cnt_r;

  // Hold counter: zero throughout IDLE so it starts at zero on grant entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_r <= '0;
    end else if (state_r == IDLE) begin
      hold_cnt_r <= '0;
    end else begin
      hold_cnt_r <= hold_cnt_r + CNT_W'(1);
    end
  end

  assign hold_expired_s = (hold_cnt_r == CNT_LAST);
`else
  assign hold_expired_s = 1'b0;
`endif

  // Next-state and output decode; done or withdrawal take precedence over timeout.
  always_comb begin
    state_s     = state_r;
    sel_s       = sel_r;
    ptr_s       = ptr_r;
    gnt_valid_s = gnt_valid_r;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_s     = GRANT;
          sel_s       = pick_idx_s;
          gnt_valid_s = 1'b1;
        end else begin
          state_s     = IDLE;
        end
      end
      GRANT: begin
        if (done || !owner_req_s) begin
          state_s     = IDLE;
          ptr_s       = idx_next(sel_r);
          gnt_valid_s = 1'b0;
        end else if (hold_expired_s) begin
          state_s     = IDLE;
          ptr_s       = idx_next(sel_r);
          gnt_valid_s = 1'b0;
          timeout_s   = 1'b1;
        end else begin
          state_s     = GRANT;
        end
      end
      default: begin
        state_s     = IDLE;
        gnt_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      sel_r       <= 3'd0;
      ptr_r       <= 3'd0;
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      sel_r       <= sel_s;
      ptr_r       <= ptr_s;
      gnt_valid_r <= gnt_valid_s;
      timeout_r   <= timeout_s;
    end
  end

  assign gnt_valid     = gnt_valid_r;
  assign {s2, s1, s0}  = sel_r;
  assign timeout       = timeout_r;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Self-checking bench for rr_sel_arbiter: directed steps plus random traffic
// compared against a cycle-level reference model of the arbitration rules.
module tb_rr_sel_arbiter;

  localparam int HOLD = 4;
`ifdef RR_HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic       gnt_valid, s2, s1, s0, timeout;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit m_busy;
  int m_sel;
  int m_ptr;
  int m_cnt;
  bit m_to;

  rr_sel_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt_valid (gnt_valid),
    .s2        (s2),
    .s1        (s1),
    .s0        (s0),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_busy = 1'b0;
    m_sel  = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    m_to   = 1'b0;
  endtask

  task automatic m_release();
    m_ptr  = (m_sel + 1) % 8;
    m_busy = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_gnt"}, {7'd0, gnt_valid}, {7'd0, m_busy});
    chk({tag, "_sel"}, {5'd0, s2, s1, s0}, 8'(m_sel));
    chk({tag, "_to"},  {7'd0, timeout},   {7'd0, m_to});
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after it.
  task automatic cycle(input logic [7:0] r, input logic d, input string tag);
    req  = r;
    done = d;
    @(posedge clk);
    m_to = 1'b0;
    if (!m_busy) begin
      if (r != 8'h00) begin
        m_sel  = pick(r, m_ptr);
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (d || !r[m_sel]) begin
      m_release();
    end else if (TO_EN && m_cnt == HOLD - 1) begin
      m_release();
      m_to = 1'b1;
    end else begin
      m_cnt++;
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int hi;
    int tos;
    logic [7:0] r;

    // reset state, asynchronous
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    m_reset();
    #2;
    check_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // rotation with every request held and done on each first grant cycle
    for (int g = 0; g < 9; g++) begin
      cycle(8'hFF, 1'b0, "rot_grant");
      chk("rot_order", {5'd0, s2, s1, s0}, 8'(g % 8));
      chk("rot_gnt_hi", {7'd0, gnt_valid}, 8'd1);
      cycle(8'hFF, 1'b1, "rot_rel");
      chk("rot_gap", {7'd0, gnt_valid}, 8'd0);
    end

    // single request, then done
    cycle(8'h20, 1'b0, "single");
    chk("single_sel", {5'd0, s2, s1, s0}, 8'd5);
    cycle(8'h20, 1'b1, "single_done");
    chk("single_rel", {7'd0, gnt_valid}, 8'd0);
    for (int i = 0; i < 10; i++) cycle(8'h00, 1'b0, "idle_hold");

    // wrap: pointer is past 5, so 0 wins over 5
    cycle(8'h21, 1'b0, "wrap");
    chk("wrap_sel", {5'd0, s2, s1, s0}, 8'd0);
    cycle(8'h21, 1'b1, "wrap_done");

    // withdrawal releases without done
    cycle(8'h08, 1'b0, "wd_grant");
    chk("wd_sel", {5'd0, s2, s1, s0}, 8'd3);
    cycle(8'h00, 1'b0, "wd_release");
    chk("wd_rel", {7'd0, gnt_valid}, 8'd0);

    // async reset in the middle of a grant, checked before the next edge
    cycle(8'h08, 1'b0, "ar_grant");
    rst_n = 1'b0;
    #1;
    m_reset();
    check_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // held request with no done
    hi  = 0;
    tos = 0;
    if (TO_EN) begin
      for (int i = 0; i < 10; i++) begin
        cycle(8'h01, 1'b0, "tmo");
        hi  += int'(gnt_valid);
        tos += int'(timeout);
        if (i == 4) chk("tmo_first_drop", {7'd0, gnt_valid}, 8'd0);
      end
      chk("tmo_hi_cycles", 8'(hi), 8'd8);
      chk("tmo_pulses", 8'(tos), 8'd2);
    end else begin
      for (int i = 0; i < 110; i++) begin
        cycle(8'h01, 1'b0, "hold");
        hi  += int'(gnt_valid);
        tos += int'(timeout);
      end
      chk("hold_hi_cycles", 8'(hi), 8'd110);
      chk("hold_no_timeout", 8'(tos), 8'd0);
    end
    cycle(8'h00, 1'b0, "tmo_end");

    // random traffic with sticky requests so grants sometimes run long
    r = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom_range(0, 255));
      cycle(r, ($urandom_range(0, 5) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
